// File: rtl/control_unit.sv
// Instruction decoder: maps the opcode/func fields of ir onto registered datapath
// control signals, one cycle after the instruction is presented.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  output logic [3:0]  alu_op,
  output logic [1:0]  alusc,
  output logic [1:0]  wrreg,
  output logic        sigwr,
  output logic        sigon,
  output logic [1:0]  res,
  output logic [2:0]  br,
  output logic [2:0]  st
);

  logic [5:0] w_opcode;
  logic [3:0] w_func;
  logic [3:0] w_alu_op;
  logic [1:0] w_alusc;
  logic [1:0] w_wrreg;
  logic       w_sigwr;
  logic       w_sigon;
  logic [1:0] w_res;
  logic [2:0] w_br;
  logic [2:0] w_st;

  assign w_opcode = ir[31:26];
  assign w_func   = ir[3:0];

  // Everything defaults to zero so unlisted opcodes/funcs decode as a nop.
  always_comb begin
    w_alu_op = 4'd0;
    w_alusc  = 2'd0;
    w_wrreg  = 2'd0;
    w_sigwr  = 1'b0;
    w_sigon  = 1'b0;
    w_res    = 2'd0;
    w_br     = 3'd0;
    w_st     = 3'd0;
    case (w_opcode)
      6'b000000: begin
        if (w_func <= 4'd8) begin
          w_alu_op = w_func;
          w_wrreg  = 2'd1;
          w_res    = 2'd2;
        end
      end
      6'b000001, 6'b000010, 6'b000011, 6'b000100: begin
        case (w_opcode)
          6'b000010: w_alu_op = 4'd2;
          6'b000011: w_alu_op = 4'd3;
          6'b000100: w_alu_op = 4'd4;
          default:   w_alu_op = 4'd0;
        endcase
        w_alusc = 2'd1;
        w_wrreg = 2'd2;
        w_res   = 2'd2;
      end
      6'b000101: begin
        w_alusc = 2'd1;
        w_sigon = 1'b1;
        w_wrreg = 2'd2;
        w_res   = 2'd3;
      end
      6'b000110: begin
        w_alusc = 2'd1;
        w_sigon = 1'b1;
        w_sigwr = 1'b1;
      end
      6'b000111: begin
        w_br    = 3'd1;
        w_alusc = 2'd3;
      end
      6'b001000: begin
        w_br    = 3'd2;
        w_alusc = 2'd2;
      end
      6'b001001: begin
        w_br    = 3'd3;
        w_alusc = 2'd2;
      end
      6'b001010: begin
        w_br    = 3'd4;
        w_alusc = 2'd2;
      end
      6'b001011: begin
        w_st    = 3'd1;
        w_alusc = 2'd1;
      end
      6'b001100: begin
        w_st    = 3'd2;
        w_alusc = 2'd1;
        w_wrreg = 2'd2;
        w_res   = 2'd3;
      end
      6'b001101: begin
        w_res   = 2'd1;
        w_wrreg = 2'd2;
      end
      default: ;
    endcase
  end

  logic [3:0] r_alu_op;
  logic [1:0] r_alusc;
  logic [1:0] r_wrreg;
  logic       r_sigwr;
  logic       r_sigon;
  logic [1:0] r_res;
  logic [2:0] r_br;
  logic [2:0] r_st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_op <= 4'd0;
      r_alusc  <= 2'd0;
      r_wrreg  <= 2'd0;
      r_sigwr  <= 1'b0;
      r_sigon  <= 1'b0;
      r_res    <= 2'd0;
      r_br     <= 3'd0;
      r_st     <= 3'd0;
    end else begin
      r_alu_op <= w_alu_op;
      r_alusc  <= w_alusc;
      r_wrreg  <= w_wrreg;
      r_sigwr  <= w_sigwr;
      r_sigon  <= w_sigon;
      r_res    <= w_res;
      r_br     <= w_br;
      r_st     <= w_st;
    end
  end

  assign alu_op = r_alu_op;
  assign alusc  = r_alusc;
  assign wrreg  = r_wrreg;
  assign sigwr  = r_sigwr;
  assign sigon  = r_sigon;
  assign res    = r_res;
  assign br     = r_br;
  assign st     = r_st;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table of opcode/func vectors with randomised operand
// fields, plus reset and back-to-back sequences, checked through an expected queue.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] ir;
  logic [3:0]  alu_op;
  logic [1:0]  alusc;
  logic [1:0]  wrreg;
  logic        sigwr;
  logic        sigon;
  logic [1:0]  res;
  logic [2:0]  br;
  logic [2:0]  st;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .ir(ir),
    .alu_op(alu_op), .alusc(alusc), .wrreg(wrreg), .sigwr(sigwr),
    .sigon(sigon), .res(res), .br(br), .st(st)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [17:0] exp;
    string       name;
  } vec_t;

  logic [17:0] exp_q[$];
  vec_t        tbl[$];
  int          total = 0;
  int          bad = 0;

  // {alu_op, alusc, wrreg, sigwr, sigon, res, br, st}
  function automatic logic [17:0] pk(input int a, input int sc, input int wr,
                                     input int sw, input int so, input int rs,
                                     input int b, input int s);
    pk = {a[3:0], sc[1:0], wr[1:0], sw[0], so[0], rs[1:0], b[2:0], s[2:0]};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input logic [17:0] e, input string n);
    vec_t v;
    v.ir = i; v.exp = e; v.name = n;
    return v;
  endfunction

  // driver: present ir/rst_n, record expectation, then check after the edge
  task automatic step(input logic [31:0] i, input logic rn, input logic [17:0] e,
                      input string n);
    logic [17:0] act;
    logic [17:0] want;
    @(negedge clk);
    ir = i;
    rst_n = rn;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    act = {alu_op, alusc, wrreg, sigwr, sigon, res, br, st};
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s ir=%h got=%h want=%h", n, i, act, want);
    end
  endtask

  logic [17:0] z;
  logic [31:0] r;
  logic [31:0] keep;

  initial begin
    z = 18'd0;
    rst_n = 1'b0;
    ir = 32'h0;

    for (int f = 0; f < 16; f++)
      tbl.push_back(mk(32'h0 | f, (f <= 8) ? pk(f, 0, 1, 0, 0, 2, 0, 0) : z, "rtype"));
    tbl.push_back(mk({6'd1, 26'd0},  pk(0, 1, 2, 0, 0, 2, 0, 0), "addi"));
    tbl.push_back(mk({6'd2, 26'd0},  pk(2, 1, 2, 0, 0, 2, 0, 0), "andi"));
    tbl.push_back(mk({6'd3, 26'd0},  pk(3, 1, 2, 0, 0, 2, 0, 0), "ori"));
    tbl.push_back(mk({6'd4, 26'd0},  pk(4, 1, 2, 0, 0, 2, 0, 0), "xori"));
    tbl.push_back(mk({6'd5, 26'd0},  pk(0, 1, 2, 0, 1, 3, 0, 0), "lw"));
    tbl.push_back(mk({6'd6, 26'd0},  pk(0, 1, 0, 1, 1, 0, 0, 0), "sw"));
    tbl.push_back(mk({6'd7, 26'd0},  pk(0, 3, 0, 0, 0, 0, 1, 0), "b"));
    tbl.push_back(mk({6'd8, 26'd0},  pk(0, 2, 0, 0, 0, 0, 2, 0), "bgtz"));
    tbl.push_back(mk({6'd9, 26'd0},  pk(0, 2, 0, 0, 0, 0, 3, 0), "bltz"));
    tbl.push_back(mk({6'd10, 26'd0}, pk(0, 2, 0, 0, 0, 0, 4, 0), "bz"));
    tbl.push_back(mk({6'd11, 26'd0}, pk(0, 1, 0, 0, 0, 0, 0, 1), "push"));
    tbl.push_back(mk({6'd12, 26'd0}, pk(0, 1, 2, 0, 0, 3, 0, 2), "pop"));
    tbl.push_back(mk({6'd13, 26'd0}, pk(0, 0, 2, 0, 0, 1, 0, 0), "mov"));
    tbl.push_back(mk({6'd14, 26'd0}, z, "undef14"));
    tbl.push_back(mk({6'd32, 26'd0}, z, "undef32"));
    tbl.push_back(mk({6'd63, 26'd0}, z, "undef63"));

    // reset state, including reset overriding a valid instruction
    step(32'h0000_0000, 1'b0, z, "reset");
    step(32'h1443_0008, 1'b0, z, "reset_lw");

    // directed vectors
    step(32'h0022_0804, 1'b1, pk(4, 0, 1, 0, 0, 2, 0, 0), "xor_vec");
    step(32'h1443_0008, 1'b1, pk(0, 1, 2, 0, 1, 3, 0, 0), "lw_vec");
    step(32'h1843_0008, 1'b1, pk(0, 1, 0, 1, 1, 0, 0, 0), "sw_vec");
    step(32'h1C00_0005, 1'b1, pk(0, 3, 0, 0, 0, 0, 1, 0), "b_after_sw");
    step(32'h2820_0003, 1'b1, pk(0, 2, 0, 0, 0, 0, 4, 0), "bz_vec");
    step(32'hFC00_0000, 1'b1, z, "undef_after_bz");

    // table with randomised operand bits: decode must ignore them
    for (int rep = 0; rep < 3; rep++) begin
      foreach (tbl[k]) begin
        r = $urandom_range(32'hFFFF_FFFF, 0);
        keep = (tbl[k].ir[31:26] == 6'd0) ? 32'hFC00_000F : 32'hFC00_0000;
        step((tbl[k].ir & keep) | (r & ~keep), 1'b1, tbl[k].exp, tbl[k].name);
      end
    end

    // one-cycle reset pulse with a held instruction
    step(32'h3000_1234, 1'b1, pk(0, 1, 2, 0, 0, 3, 0, 2), "pop_pre_rst");
    step(32'h3000_1234, 1'b0, z, "pop_in_rst");
    step(32'h3000_1234, 1'b1, pk(0, 1, 2, 0, 0, 3, 0, 2), "pop_post_rst");
    step(32'h0000_0009, 1'b1, z, "rtype_nop_boundary");
    step(32'h0000_0008, 1'b1, pk(8, 0, 1, 0, 0, 2, 0, 0), "rtype_neg_boundary");

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
